exec_seq: RTL and testbench
===========================

EXEC_SEQ -- requirements
Module: exec_seq

Interface
REQ-001 Parameter REG_W, default 4, register-index width.
REQ-002 Parameter MUL_LAT, default 3, multiplier latency in cycles; legal range 1..15.
REQ-003 clk  input  1  main clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 inValid / inReady  input / output  1 / 1  decode-to-execute handshake; an instruction is accepted on a rising edge where both are 1.
REQ-006 instId, opcode, shift, cond  input  3, 3, 2, 2  instruction class (INST_* codes), ALU op (OP_* codes), shift type (SH_* codes), condition.
REQ-007 rs1Idx, rs2Idx, rdIdx  input  REG_W each  source and destination indices.
REQ-008 immFlag, cmpFlag  input  1 each  immediate operand; compare (no writeback).
REQ-009 flags  input  4  status {N,Z,C,V}, sampled only on the accept edge.
REQ-010 memRdy  input  1  data memory completes the current access.
REQ-011 aluCtl, shiftCtl  output  3 each  registered unit controls.
REQ-012 aluOEn, shiftOEn, mulOEn, immOEn, rdBOEn  output  1 each  datapath output enables.
REQ-013 opAIdx, opBIdx, wbIdx  output  REG_W each  operand and writeback indices.
REQ-014 wbEn, iAregCtl, dAregCtl, dInCtl, dOutCtl  output  1 each  writeback and address/data bus controls.
REQ-015 busy, annul  output  1 each  multi-cycle op in progress; current instruction squashed.

Function
REQ-016 The FSM SHALL have four states: IDLE, EXEC, MUL, MEM; inReady=1 in IDLE and EXEC and 0 in MUL and MEM.
REQ-017 On accept, fields SHALL be latched; next state is MUL for INST_MUL, MEM for INST_LOAD/INST_STORE, and EXEC for all other classes; the controls are valid in the cycle after accept.
REQ-018 Condition evaluation: cond 00 always, 01 Z=1, 10 Z=0, 11 C=1; a false condition or an undefined instId SHALL go to EXEC with annul=1 and every enable 0 for one cycle.
REQ-019 EXEC with no acceptance in the same cycle SHALL return to IDLE; EXEC with acceptance SHALL dispatch per REQ-017, giving back-to-back single-cycle throughput.
REQ-020 ALUI: aluOEn=1, immOEn=1, opAIdx=rdIdx; ALUR: aluOEn=1, rdBOEn=1, opAIdx=rs1Idx, opBIdx=rs2Idx; SHRO: shiftOEn=1, rs1/rs2 operands.
REQ-021 BRANCH: aluCtl=100, aluOEn=1, immOEn=1, iAregCtl=1, opAIdx=all ones, wbEn=0.
REQ-022 aluCtl mapping: MOV reg 000, MOV imm 001, ADD 100, SUB 111, AND 010, OR 011, CMP 110, MSR/MRS 000; shiftCtl mapping: LSL 000, LSR 100, ASR 101, ROR 110.
REQ-023 wbEn SHALL be 1 in EXEC for ALUI, ALUR and SHRO only when cmpFlag=0, with wbIdx=rdIdx.
REQ-024 MUL: the state SHALL last exactly MUL_LAT cycles, tracked by a down-counter loaded with MUL_LAT-1; busy=1 throughout; mulOEn and wbEn SHALL be 1 only in the final cycle; the next state is IDLE.
REQ-025 MEM: dAregCtl=1 and busy=1 every cycle; LOAD drives dInCtl=1, STORE drives dOutCtl=1 with opBIdx=rdIdx; opAIdx=rs1Idx.
REQ-026 MEM SHALL exit to IDLE in the cycle after memRdy=1; LOAD wbEn=1 only in the memRdy cycle; memRdy=1 in the first MEM cycle gives a 1-cycle access; there is no timeout.
REQ-027 All unused enables SHALL be 0; unused index outputs SHALL be 0; no X SHALL reach any output.
REQ-028 In IDLE all outputs except inReady SHALL be 0.

Reset
REQ-029 reset SHALL force state IDLE, counter 0, all outputs 0 and inReady=1 immediately, without waiting for clk.
REQ-030 A reset during MUL or MEM SHALL abort the operation with no wbEn pulse; the first accept after reset release behaves normally.

Verification
REQ-031 Back-to-back ALUR ADD r1,r2->r3 then ALUI: cycle 1 aluCtl=100, wbEn=1, opAIdx=1, opBIdx=2, wbIdx=3; cycle 2 immOEn=1; inReady remains 1.
REQ-032 MUL with MUL_LAT=3: busy=1 for 3 cycles, mulOEn=wbEn=1 only in the 3rd cycle, inReady=0 for 3 cycles.
REQ-033 LOAD with memRdy low 2 cycles then high: dAregCtl=dInCtl=1 for 3 cycles, wbEn=1 only in the 3rd cycle; STORE gives dOutCtl=1 and wbEn=0.
REQ-034 BRANCH with cond=01 and Z=0: annul=1 for 1 cycle with iAregCtl=0; with Z=1: iAregCtl=1 and opAIdx=all ones.
REQ-035 CMP with cmpFlag=1: aluCtl=110, aluOEn=1, wbEn=0.
REQ-036 Reset asserted in the 2nd MUL cycle: outputs 0 asynchronously, no mulOEn/wbEn, inReady=1; the next ALU instruction executes correctly.

Source files
------------

// File: rtl/exec_seq.sv
// ---------------------------------------------------------------------------
// exec_seq -- execute-stage control sequencer.
//
// Accepts one decoded instruction per cycle over a valid/ready handshake,
// evaluates its condition against the flags sampled on the accept edge, and
// drives the datapath unit controls, operand/writeback indices and memory bus
// controls. Single-cycle classes run in EXEC; multiplies hold MUL for MUL_LAT
// cycles; loads/stores hold MEM until the memory signals completion.
//
// Ports
//   clk, reset                      clock, async active-high reset
//   inValid / inReady               instruction handshake
//   instId, opcode, shift, cond     instruction class, ALU op, shift type, condition
//   rs1Idx, rs2Idx, rdIdx           register indices
//   immFlag, cmpFlag                immediate operand, compare-only
//   flags                           {N,Z,C,V}, sampled on accept
//   memRdy                          memory access completes this cycle
//   aluCtl, shiftCtl                unit controls
//   aluOEn..rdBOEn                  datapath output enables
//   opAIdx, opBIdx, wbIdx           operand and writeback indices
//   wbEn, iAregCtl, dAregCtl,
//   dInCtl, dOutCtl                 writeback and bus controls
//   busy, annul                     multi-cycle op active, instruction squashed
//
// Codes
//   instId : 0 ALUI, 1 ALUR, 2 SHRO, 3 BRANCH, 4 MUL, 5 LOAD, 6 STORE, 7 undefined
//   opcode : 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 CMP, 6 MSR, 7 MRS
//   shift  : 0 LSL, 1 LSR, 2 ASR, 3 ROR
// ---------------------------------------------------------------------------
module exec_seq #(
    parameter int REG_W   = 4,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [2:0]       instId,
    input  logic [2:0]       opcode,
    input  logic [1:0]       shift,
    input  logic [1:0]       cond,
    input  logic [REG_W-1:0] rs1Idx,
    input  logic [REG_W-1:0] rs2Idx,
    input  logic [REG_W-1:0] rdIdx,
    input  logic             immFlag,
    input  logic             cmpFlag,
    input  logic [3:0]       flags,
    input  logic             memRdy,
    output logic [2:0]       aluCtl,
    output logic [2:0]       shiftCtl,
    output logic             aluOEn,
    output logic             shiftOEn,
    output logic             mulOEn,
    output logic             immOEn,
    output logic             rdBOEn,
    output logic [REG_W-1:0] opAIdx,
    output logic [REG_W-1:0] opBIdx,
    output logic [REG_W-1:0] wbIdx,
    output logic             wbEn,
    output logic             iAregCtl,
    output logic             dAregCtl,
    output logic             dInCtl,
    output logic             dOutCtl,
    output logic             busy,
    output logic             annul
);

    localparam logic [2:0] INST_ALUI   = 3'd0;
    localparam logic [2:0] INST_ALUR   = 3'd1;
    localparam logic [2:0] INST_SHRO   = 3'd2;
    localparam logic [2:0] INST_BRANCH = 3'd3;
    localparam logic [2:0] INST_MUL    = 3'd4;
    localparam logic [2:0] INST_LOAD   = 3'd5;
    localparam logic [2:0] INST_STORE  = 3'd6;

    localparam logic [2:0] OP_MOV = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_CMP = 3'd5;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_MEM
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_inst;
    logic [2:0]       r_aluCtl;
    logic [2:0]       r_shCtl;
    logic [REG_W-1:0] r_rs1;
    logic [REG_W-1:0] r_rs2;
    logic [REG_W-1:0] r_rd;
    logic             r_cmp;
    logic             r_annul;
    logic [3:0]       r_cnt;

    logic             w_accept;
    logic             w_cond_ok;
    logic             w_squash;
    logic [2:0]       w_alu_code;
    logic [2:0]       w_sh_code;
    logic             w_unused;

    // Only Z and C take part in condition evaluation.
    assign w_unused = ^{flags[3], flags[0]};

    assign w_accept = inValid & inReady;

    always_comb begin
        w_cond_ok = 1'b1;
        case (cond)
            2'b00: w_cond_ok = 1'b1;
            2'b01: w_cond_ok = flags[2];
            2'b10: w_cond_ok = ~flags[2];
            2'b11: w_cond_ok = flags[1];
            default: w_cond_ok = 1'b1;
        endcase
    end

    assign w_squash = ~w_cond_ok | (instId == 3'd7);

    always_comb begin
        w_alu_code = 3'b000;
        if (instId == INST_BRANCH) begin
            w_alu_code = 3'b100;
        end else begin
            case (opcode)
                OP_MOV:  w_alu_code = {2'b00, immFlag};
                OP_ADD:  w_alu_code = 3'b100;
                OP_SUB:  w_alu_code = 3'b111;
                OP_AND:  w_alu_code = 3'b010;
                OP_OR:   w_alu_code = 3'b011;
                OP_CMP:  w_alu_code = 3'b110;
                default: w_alu_code = 3'b000;   // MSR / MRS
            endcase
        end
    end

    always_comb begin
        w_sh_code = 3'b110;                     // ROR
        case (shift)
            SH_LSL:  w_sh_code = 3'b000;
            SH_LSR:  w_sh_code = 3'b100;
            SH_ASR:  w_sh_code = 3'b101;
            default: w_sh_code = 3'b110;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_EXEC: begin
                if (w_accept) begin
                    if (w_squash)                   w_state_nxt = S_EXEC;
                    else if (instId == INST_MUL)    w_state_nxt = S_MUL;
                    else if (instId == INST_LOAD ||
                             instId == INST_STORE)  w_state_nxt = S_MEM;
                    else                            w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL:   if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
            S_MEM:   if (memRdy)        w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_inst   <= '0;
            r_aluCtl <= '0;
            r_shCtl  <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_cmp    <= 1'b0;
            r_annul  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_inst   <= instId;
                r_aluCtl <= w_alu_code;
                r_shCtl  <= w_sh_code;
                r_rs1    <= rs1Idx;
                r_rs2    <= rs2Idx;
                r_rd     <= rdIdx;
                r_cmp    <= cmpFlag;
                r_annul  <= w_squash;
                r_cnt    <= CNT_LOAD;
            end else if (r_state == S_MUL && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Output decode from the registered state and latched fields.
    always_comb begin
        inReady  = 1'b0;
        aluCtl   = '0;
        shiftCtl = '0;
        aluOEn   = 1'b0;
        shiftOEn = 1'b0;
        mulOEn   = 1'b0;
        immOEn   = 1'b0;
        rdBOEn   = 1'b0;
        opAIdx   = '0;
        opBIdx   = '0;
        wbIdx    = '0;
        wbEn     = 1'b0;
        iAregCtl = 1'b0;
        dAregCtl = 1'b0;
        dInCtl   = 1'b0;
        dOutCtl  = 1'b0;
        busy     = 1'b0;
        annul    = 1'b0;
        case (r_state)
            S_IDLE: inReady = 1'b1;
            S_EXEC: begin
                inReady = 1'b1;
                if (r_annul) begin
                    annul = 1'b1;
                end else begin
                    case (r_inst)
                        INST_ALUI: begin
                            aluCtl = r_aluCtl;
                            aluOEn = 1'b1;
                            immOEn = 1'b1;
                            opAIdx = r_rd;
                            wbEn   = ~r_cmp;
                            wbIdx  = r_cmp ? '0 : r_rd;
                        end
                        INST_ALUR: begin
                            aluCtl = r_aluCtl;
                            aluOEn = 1'b1;
                            rdBOEn = 1'b1;
                            opAIdx = r_rs1;
                            opBIdx = r_rs2;
                            wbEn   = ~r_cmp;
                            wbIdx  = r_cmp ? '0 : r_rd;
                        end
                        INST_SHRO: begin
                            shiftCtl = r_shCtl;
                            shiftOEn = 1'b1;
                            opAIdx   = r_rs1;
                            opBIdx   = r_rs2;
                            wbEn     = ~r_cmp;
                            wbIdx    = r_cmp ? '0 : r_rd;
                        end
                        INST_BRANCH: begin
                            aluCtl   = r_aluCtl;
                            aluOEn   = 1'b1;
                            immOEn   = 1'b1;
                            iAregCtl = 1'b1;
                            opAIdx   = '1;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                busy   = 1'b1;
                opAIdx = r_rs1;
                opBIdx = r_rs2;
                if (r_cnt == 4'd0) begin
                    mulOEn = 1'b1;
                    wbEn   = 1'b1;
                    wbIdx  = r_rd;
                end
            end
            S_MEM: begin
                busy     = 1'b1;
                dAregCtl = 1'b1;
                opAIdx   = r_rs1;
                if (r_inst == INST_LOAD) begin
                    dInCtl = 1'b1;
                    wbEn   = memRdy;
                    wbIdx  = memRdy ? r_rd : '0;
                end else begin
                    dOutCtl = 1'b1;
                    opBIdx  = r_rd;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exec_seq.sv
// ---------------------------------------------------------------------------
// tb_exec_seq -- scoreboard bench for exec_seq.
// Inputs change 1 time unit after each rising edge; outputs are sampled on the
// falling edge. Every driven cycle pushes the outputs expected in that cycle;
// the falling-edge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_exec_seq;

    localparam int REG_W   = 4;
    localparam int MUL_LAT = 3;

    localparam logic [2:0] I_ALUI = 3'd0, I_ALUR = 3'd1, I_SHRO = 3'd2, I_BR = 3'd3;
    localparam logic [2:0] I_MUL = 3'd4, I_LOAD = 3'd5, I_STORE = 3'd6, I_UNDEF = 3'd7;
    localparam logic [2:0] O_MOV = 3'd0, O_ADD = 3'd1, O_SUB = 3'd2, O_AND = 3'd3;
    localparam logic [2:0] O_OR = 3'd4, O_CMP = 3'd5, O_MSR = 3'd6, O_MRS = 3'd7;

    typedef struct packed {
        logic             inReady, busy, annul;
        logic [2:0]       aluCtl, shiftCtl;
        logic             aluOEn, shiftOEn, mulOEn, immOEn, rdBOEn;
        logic [REG_W-1:0] opA, opB, wbIdx;
        logic             wbEn, iAreg, dAreg, dIn, dOut;
    } out_t;

    typedef struct packed {
        logic [2:0]       inst, op;
        logic [1:0]       sh, cond;
        logic [REG_W-1:0] rs1, rs2, rd;
        logic             imm, cmp;
        logic [3:0]       fl;
    } ins_t;

    logic             clk = 1'b0;
    logic             reset, inValid, inReady, immFlag, cmpFlag, memRdy;
    logic [2:0]       instId, opcode, aluCtl, shiftCtl;
    logic [1:0]       shift, cond;
    logic [REG_W-1:0] rs1Idx, rs2Idx, rdIdx, opAIdx, opBIdx, wbIdx;
    logic [3:0]       flags;
    logic             aluOEn, shiftOEn, mulOEn, immOEn, rdBOEn;
    logic             wbEn, iAregCtl, dAregCtl, dInCtl, dOutCtl, busy, annul;

    exec_seq #(.REG_W(REG_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .instId(instId), .opcode(opcode), .shift(shift), .cond(cond),
        .rs1Idx(rs1Idx), .rs2Idx(rs2Idx), .rdIdx(rdIdx),
        .immFlag(immFlag), .cmpFlag(cmpFlag), .flags(flags), .memRdy(memRdy),
        .aluCtl(aluCtl), .shiftCtl(shiftCtl), .aluOEn(aluOEn), .shiftOEn(shiftOEn),
        .mulOEn(mulOEn), .immOEn(immOEn), .rdBOEn(rdBOEn),
        .opAIdx(opAIdx), .opBIdx(opBIdx), .wbIdx(wbIdx), .wbEn(wbEn),
        .iAregCtl(iAregCtl), .dAregCtl(dAregCtl), .dInCtl(dInCtl), .dOutCtl(dOutCtl),
        .busy(busy), .annul(annul)
    );

    always #5 clk = ~clk;

    out_t got;
    assign got = {inReady, busy, annul, aluCtl, shiftCtl, aluOEn, shiftOEn, mulOEn,
                  immOEn, rdBOEn, opAIdx, opBIdx, wbIdx, wbEn, iAregCtl, dAregCtl,
                  dInCtl, dOutCtl};

    int    n_vec = 0;
    int    n_err = 0;
    out_t  exp_q[$];
    string tag_q[$];
    out_t  m_exp[$];
    logic  m_rdy[$];
    out_t  cur;
    string cur_tag;

    task automatic check_out(input string tag, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            out_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_out(t, got, e);
        end
    end

    function automatic out_t idle_o();
        out_t o = '0;
        o.inReady = 1'b1;
        return o;
    endfunction

    function automatic logic [2:0] alu_code(input logic [2:0] op, input logic imm);
        case (op)
            O_MOV:   return imm ? 3'b001 : 3'b000;
            O_ADD:   return 3'b100;
            O_SUB:   return 3'b111;
            O_AND:   return 3'b010;
            O_OR:    return 3'b011;
            O_CMP:   return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] sh_code(input logic [1:0] sh);
        case (sh)
            2'd0:    return 3'b000;
            2'd1:    return 3'b100;
            2'd2:    return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    function automatic logic cond_ok(input logic [1:0] c, input logic [3:0] fl);
        case (c)
            2'b00:   return 1'b1;
            2'b01:   return fl[2];
            2'b10:   return ~fl[2];
            default: return fl[1];
        endcase
    endfunction

    // Expected outputs in the cycle after a single-cycle (or squashed) accept.
    function automatic out_t exec_o(input ins_t s);
        out_t o = idle_o();
        if (!cond_ok(s.cond, s.fl) || s.inst == I_UNDEF) begin
            o.annul = 1'b1;
            return o;
        end
        case (s.inst)
            I_ALUI: begin
                o.aluCtl = alu_code(s.op, s.imm); o.aluOEn = 1'b1; o.immOEn = 1'b1;
                o.opA = s.rd;
            end
            I_ALUR: begin
                o.aluCtl = alu_code(s.op, s.imm); o.aluOEn = 1'b1; o.rdBOEn = 1'b1;
                o.opA = s.rs1; o.opB = s.rs2;
            end
            I_SHRO: begin
                o.shiftCtl = sh_code(s.sh); o.shiftOEn = 1'b1;
                o.opA = s.rs1; o.opB = s.rs2;
            end
            I_BR: begin
                o.aluCtl = 3'b100; o.aluOEn = 1'b1; o.immOEn = 1'b1; o.iAreg = 1'b1;
                o.opA = '1;
            end
            default: ;
        endcase
        if ((s.inst == I_ALUI || s.inst == I_ALUR || s.inst == I_SHRO) && !s.cmp) begin
            o.wbEn = 1'b1; o.wbIdx = s.rd;
        end
        return o;
    endfunction

    function automatic out_t mul_o(input ins_t s, input logic last);
        out_t o = '0;
        o.busy = 1'b1; o.opA = s.rs1; o.opB = s.rs2;
        if (last) begin
            o.mulOEn = 1'b1; o.wbEn = 1'b1; o.wbIdx = s.rd;
        end
        return o;
    endfunction

    function automatic out_t mem_o(input ins_t s, input logic rdy);
        out_t o = '0;
        o.busy = 1'b1; o.dAreg = 1'b1; o.opA = s.rs1;
        if (s.inst == I_LOAD) begin
            o.dIn = 1'b1;
            if (rdy) begin o.wbEn = 1'b1; o.wbIdx = s.rd; end
        end else begin
            o.dOut = 1'b1; o.opB = s.rd;
        end
        return o;
    endfunction

    function automatic ins_t mk(input logic [2:0] inst, input logic [2:0] op,
                                input logic [1:0] sh, input logic [1:0] c,
                                input int rs1, input int rs2, input int rd,
                                input logic imm, input logic cmp, input logic [3:0] fl);
        ins_t s;
        s.inst = inst; s.op = op; s.sh = sh; s.cond = c;
        s.rs1 = REG_W'(rs1); s.rs2 = REG_W'(rs2); s.rd = REG_W'(rd);
        s.imm = imm; s.cmp = cmp; s.fl = fl;
        return s;
    endfunction

    task automatic tick(input out_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ins_t s);
        inValid = 1'b1;
        instId = s.inst; opcode = s.op; shift = s.sh; cond = s.cond;
        rs1Idx = s.rs1; rs2Idx = s.rs2; rdIdx = s.rd;
        immFlag = s.imm; cmpFlag = s.cmp; flags = s.fl; memRdy = 1'b0;
    endtask

    task automatic issue1(input ins_t s, input string tag);
        drive(s);
        tick(cur, cur_tag);
        inValid = 1'b0;
        cur     = exec_o(s);
        cur_tag = tag;
    endtask

    task automatic idle();
        inValid = 1'b0;
        tick(cur, cur_tag);
        cur     = idle_o();
        cur_tag = "idle";
    endtask

    // Multi-cycle op: m_exp/m_rdy hold one entry per post-accept cycle.
    task automatic issue_multi(input ins_t s, input string tag);
        drive(s);
        tick(cur, cur_tag);
        inValid = 1'b0;
        for (int i = 0; i < m_exp.size(); i++) begin
            memRdy = m_rdy[i];
            tick(m_exp[i], $sformatf("%s_c%0d", tag, i));
        end
        memRdy = 1'b0;
        m_exp.delete();
        m_rdy.delete();
        cur     = idle_o();
        cur_tag = {tag, "_done"};
    endtask

    task automatic run_mul(input ins_t s, input string tag);
        for (int i = 0; i < MUL_LAT; i++) begin
            m_exp.push_back(mul_o(s, i == MUL_LAT - 1));
            m_rdy.push_back(1'b0);
        end
        issue_multi(s, tag);
    endtask

    task automatic run_mem(input ins_t s, input int waits, input string tag);
        for (int i = 0; i <= waits; i++) begin
            m_exp.push_back(mem_o(s, i == waits));
            m_rdy.push_back(i == waits);
        end
        issue_multi(s, tag);
    endtask

    initial begin
        ins_t s;
        reset = 1'b1; inValid = 1'b0; instId = '0; opcode = '0; shift = '0; cond = '0;
        rs1Idx = '0; rs2Idx = '0; rdIdx = '0; immFlag = 1'b0; cmpFlag = 1'b0;
        flags = '0; memRdy = 1'b0;
        #1 check_out("reset_state", got, idle_o());
        @(posedge clk); @(posedge clk); #1;
        reset   = 1'b0;
        cur     = idle_o();
        cur_tag = "idle";

        // Back-to-back ALUR ADD r1,r2->r3 then ALUI.
        issue1(mk(I_ALUR, O_ADD, 0, 0, 1, 2, 3, 0, 0, 4'h0), "alur_add");
        issue1(mk(I_ALUI, O_ADD, 0, 0, 0, 0, 5, 1, 0, 4'h0), "alui_add");
        for (int i = 0; i < 4; i++)
            issue1(mk(I_SHRO, O_MOV, 2'(i), 0, i + 1, i + 6, i + 10, 0, 0, 4'h0), "shro");
        issue1(mk(I_ALUR, O_CMP, 0, 0, 4, 6, 9, 0, 1, 4'h0), "cmp_r");
        issue1(mk(I_ALUI, O_CMP, 0, 0, 0, 0, 7, 1, 1, 4'h0), "cmp_i");
        issue1(mk(I_ALUR, O_SUB, 0, 0, 2, 3, 4, 0, 0, 4'h0), "sub");
        issue1(mk(I_ALUR, O_AND, 0, 0, 5, 6, 7, 0, 0, 4'h0), "and");
        issue1(mk(I_ALUR, O_OR,  0, 0, 8, 9, 10, 0, 0, 4'h0), "or");
        issue1(mk(I_ALUR, O_MOV, 0, 0, 11, 12, 13, 0, 0, 4'h0), "mov_r");
        issue1(mk(I_ALUI, O_MOV, 0, 0, 0, 0, 14, 1, 0, 4'h0), "mov_i");
        issue1(mk(I_ALUR, O_MSR, 0, 0, 1, 1, 2, 0, 0, 4'h0), "msr");
        issue1(mk(I_ALUR, O_MRS, 0, 0, 3, 3, 15, 0, 0, 4'h0), "mrs");
        idle();

        // Conditions and squash.
        issue1(mk(I_BR, O_MOV, 0, 2'b01, 0, 0, 0, 1, 0, 4'h0), "br_eq_nz");
        issue1(mk(I_BR, O_MOV, 0, 2'b01, 0, 0, 0, 1, 0, 4'h4), "br_eq_z");
        issue1(mk(I_BR, O_MOV, 0, 2'b10, 0, 0, 0, 1, 0, 4'h4), "br_ne_z");
        issue1(mk(I_BR, O_MOV, 0, 2'b11, 0, 0, 0, 1, 0, 4'h2), "br_cs_c");
        issue1(mk(I_ALUR, O_ADD, 0, 2'b11, 1, 2, 3, 0, 0, 4'h0), "add_cs_nc");
        issue1(mk(I_UNDEF, O_ADD, 0, 0, 1, 2, 3, 0, 0, 4'h0), "undef");
        issue1(mk(I_MUL, O_MOV, 0, 2'b01, 1, 2, 3, 0, 0, 4'h0), "mul_squash");
        idle();

        // Multiply, including dispatch straight out of EXEC.
        run_mul(mk(I_MUL, O_MOV, 0, 0, 2, 3, 4, 0, 0, 4'h0), "mul");
        issue1(mk(I_ALUR, O_ADD, 0, 0, 5, 6, 7, 0, 0, 4'h0), "add_pre_mul");
        run_mul(mk(I_MUL, O_MOV, 0, 0, 8, 9, 10, 0, 0, 4'h0), "mul_b2b");

        // Memory accesses.
        run_mem(mk(I_LOAD, O_MOV, 0, 0, 6, 0, 11, 0, 0, 4'h0), 2, "load_w2");
        run_mem(mk(I_LOAD, O_MOV, 0, 0, 7, 0, 12, 0, 0, 4'h0), 0, "load_w0");
        run_mem(mk(I_STORE, O_MOV, 0, 0, 8, 0, 13, 0, 0, 4'h0), 1, "store_w1");

        // Random single-cycle mix.
        for (int i = 0; i < 24; i++) begin
            s = ins_t'({$urandom, $urandom});
            case ($urandom_range(0, 4))
                0:       s.inst = I_ALUI;
                1:       s.inst = I_ALUR;
                2:       s.inst = I_SHRO;
                3:       s.inst = I_BR;
                default: s.inst = I_UNDEF;
            endcase
            issue1(s, $sformatf("rand%0d", i));
        end
        idle();

        // Reset in the second multiply cycle.
        s = mk(I_MUL, O_MOV, 0, 0, 1, 2, 3, 0, 0, 4'h0);
        drive(s);
        tick(cur, cur_tag);
        inValid = 1'b0;
        tick(mul_o(s, 1'b0), "rst_mul_c0");
        exp_q.push_back(idle_o());
        tag_q.push_back("rst_hold");
        #1 reset = 1'b1;
        #1 check_out("rst_async", got, idle_o());
        #5 reset = 1'b0;
        @(posedge clk);
        #1;
        cur     = idle_o();
        cur_tag = "rst_after";
        idle();
        idle();
        issue1(mk(I_ALUR, O_SUB, 0, 0, 9, 10, 11, 0, 0, 4'h0), "sub_after_rst");
        idle();
        idle();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
